regfile_wb_buffer: RTL

- Write-back stage directly upstream of the 32x32 register file; owns its write port (we/waddr/data).
- Accepts results from execute over valid/ready, queues them in a small FIFO and retires at most one per cycle into the register file.
- Forwards still-queued results onto the two read ports, so readers never see stale register values while writes are pending.

---
 rtl/regfile_wb_buffer_pkg.sv | 12 +
 rtl/regfile_wb_buffer_fwd.sv | 28 ++
 rtl/regfile_wb_buffer.sv | 105 ++++++++++
 3 files changed

// File: rtl/regfile_wb_buffer_pkg.sv
// Shared definitions for the register-file write-back buffer.
// Holds the register-file geometry and the queued write-back entry type.
package regfile_wb_buffer_pkg;
  localparam int WB_AW    = 5;   // register address width
  localparam int WB_DW    = 32;  // register data width
  localparam int WB_NREGS = 32;  // registers in the file

  typedef struct packed {
    logic [WB_AW-1:0] addr;
    logic [WB_DW-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/regfile_wb_buffer_fwd.sv
// wb_fwd_match: newest-match forwarding search for one read port.
// Entries arrive age-ordered, index 0 is the oldest (the FIFO head).
// Ports:
//   i_vld   per-entry valid, age-ordered
//   i_addr  per-entry destination register
//   i_data  per-entry result value
//   i_raddr read address being looked up
//   i_rfq   raw register-file read data, used when nothing matches
//   o_q     forwarded read data
module wb_fwd_match #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic [DEPTH-1:0]         i_vld,
  input  logic [DEPTH-1:0][AW-1:0] i_addr,
  input  logic [DEPTH-1:0][DW-1:0] i_data,
  input  logic [AW-1:0]            i_raddr,
  input  logic [DW-1:0]            i_rfq,
  output logic [DW-1:0]            o_q
);
  // Scan oldest to newest so the last hit (the newest write) wins.
  always_comb begin
    o_q = i_rfq;
    for (int k = 0; k < DEPTH; k++)
      if (i_vld[k] && (i_addr[k] == i_raddr)) o_q = i_data[k];
  end
endmodule

// File: rtl/regfile_wb_buffer.sv
// regfile_wb_buffer: write-back queue in front of the 32x32 register file.
// Accepts execute results over valid/ready, retires at most one per cycle
// onto the register-file write port, and forwards pending results to both
// read ports.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   in_valid/in_ready     execute handshake, in_addr/in_data payload
//   wb_hold               suppress retire this cycle
//   rf_we/rf_waddr/rf_wdata register-file write port
//   raddr1/raddr2         read addresses, rf_q1/rf_q2 raw read data
//   q1/q2                 forwarded read data
//   count/empty/full      occupancy status
// Entries use the package widths; AW/DW are expected at their defaults.
module regfile_wb_buffer
  import regfile_wb_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = WB_AW,
  parameter int DW    = WB_DW,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [AW-1:0] in_addr,
  input  logic [DW-1:0] in_data,
  input  logic          wb_hold,
  output logic          rf_we,
  output logic [AW-1:0] rf_waddr,
  output logic [DW-1:0] rf_wdata,
  input  logic [AW-1:0] raddr1,
  input  logic [AW-1:0] raddr2,
  input  logic [DW-1:0] rf_q1,
  input  logic [DW-1:0] rf_q2,
  output logic [DW-1:0] q1,
  output logic [DW-1:0] q2,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          full
);
  wb_entry_t       r_mem [DEPTH];
  logic [PW-1:0]   r_head, r_tail;
  logic [CW-1:0]   r_count;

  logic            w_push, w_pop, w_empty, w_full;

  assign w_empty  = (r_count == '0);
  assign w_full   = (r_count == CW'(DEPTH));
  assign in_ready = !w_full && !reset;
  assign w_push   = in_valid && in_ready;
  assign w_pop    = !w_empty && !wb_hold && !reset;

  assign rf_we    = w_pop;
  assign rf_waddr = w_empty ? '0 : r_mem[r_head].addr;
  assign rf_wdata = w_empty ? '0 : r_mem[r_head].data;
  assign count    = r_count;
  assign empty    = w_empty;
  assign full     = w_full;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + 1'b1;
      if (w_pop)  r_head <= r_head + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage carries no reset; occupancy alone says what is live.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_tail] <= '{addr: in_addr, data: in_data};
  end

  // Re-order entries by age from head so priority survives pointer wrap.
  logic [DEPTH-1:0]         w_age_vld;
  logic [DEPTH-1:0][AW-1:0] w_age_addr;
  logic [DEPTH-1:0][DW-1:0] w_age_data;

  for (genvar k = 0; k < DEPTH; k++) begin : g_age
    logic [PW-1:0] w_slot;
    assign w_slot        = r_head + PW'(k);
    assign w_age_vld[k]  = (CW'(k) < r_count);
    assign w_age_addr[k] = r_mem[w_slot].addr;
    assign w_age_data[k] = r_mem[w_slot].data;
  end

  wb_fwd_match #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_fwd1 (
    .i_vld(w_age_vld), .i_addr(w_age_addr), .i_data(w_age_data),
    .i_raddr(raddr1), .i_rfq(rf_q1), .o_q(q1)
  );

  wb_fwd_match #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_fwd2 (
    .i_vld(w_age_vld), .i_addr(w_age_addr), .i_data(w_age_data),
    .i_raddr(raddr2), .i_rfq(rf_q2), .o_q(q2)
  );
endmodule
